// File: rtl/count_sequencer.sv
// Up/down count sequencer with pause, stop and autoreload.
// Limit and direction are captured at start; terminal count is flagged combinationally.
module count_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       dir,
    input  logic [3:0] limit,
    input  logic       autoreload,
    output logic [3:0] cnt,
    output logic       busy,
    output logic       tc,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_limit;
    logic       r_dir;

    logic [3:0] w_term;
    logic [3:0] w_reload;
    logic [3:0] w_load;
    logic [3:0] w_step;
    logic       w_tc;

    // Up-count ends at the captured limit, down-count ends at zero.
    assign w_term   = r_dir ? 4'd0 : r_limit;
    assign w_reload = r_dir ? r_limit : 4'd0;
    assign w_load   = dir ? limit : 4'd0;
    assign w_step   = r_dir ? (r_cnt - 4'd1) : (r_cnt + 4'd1);

    assign w_tc = rst && (r_state == S_RUN) && (r_cnt == w_term)
                  && !stop && !pause;

    assign cnt  = r_cnt;
    assign tc   = w_tc;
    assign busy = (r_state == S_RUN) || (r_state == S_PAUSE);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_dir   <= 1'b0;
            r_limit <= 4'd0;
        end else if (stop) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_dir   <= dir;
                        r_limit <= limit;
                        r_cnt   <= w_load;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        r_state <= S_PAUSE;
                    end else if (w_tc) begin
                        if (autoreload) begin
                            r_cnt <= w_reload;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= w_step;
                    end
                end
                S_PAUSE: begin
                    // Leaving pause costs one edge; counting resumes after.
                    if (!pause) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-low.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst, input, 1 bit: synchronous active-low reset; 0 at a rising clk edge resets all state.
REQ-004 Port start, input, 1 bit: begin a count sequence (level-sampled, acted on in IDLE or DONE only).
REQ-005 Port stop, input, 1 bit: abort the sequence; highest priority after rst.
REQ-006 Port pause, input, 1 bit: freeze counting while high during RUN or PAUSE.
REQ-007 Port dir, input, 1 bit: 0 counts up, 1 counts down; captured at start.
REQ-008 Port limit, input, 4 bits: terminal value for up-count and reload value for down-count; captured at start.
REQ-009 Port autoreload, input, 1 bit: 1 restarts the sequence at terminal count; sampled live.
REQ-010 Port cnt, output, 4 bits: registered count value.
REQ-011 Port busy, output, 1 bit: high in RUN or PAUSE.
REQ-012 Port tc, output, 1 bit: combinational terminal-count flag.
REQ-013 Port done, output, 1 bit: high for exactly the one cycle spent in DONE.

Function
REQ-014 The FSM SHALL have four states, IDLE, RUN, PAUSE and DONE, in a 2-bit state register.
REQ-015 In IDLE or DONE with start=1 and stop=0, the block SHALL go to RUN, capture dir_q and limit_q, and load cnt with 0 when dir=0 or with limit when dir=1.
REQ-016 In RUN with stop=0 and pause=0, cnt SHALL change by +1 when dir_q=0 or by -1 when dir_q=1 on each edge, unless tc=1.
REQ-017 The terminal value SHALL be limit_q when dir_q=0 and 0 when dir_q=1.
REQ-018 tc SHALL be 1 only when state=RUN, cnt equals the terminal value, stop=0 and pause=0.
REQ-019 On an edge with tc=1 and autoreload=1, cnt SHALL reload its start value and the state SHALL remain RUN.
REQ-020 On an edge with tc=1 and autoreload=0, the state SHALL go to DONE and cnt SHALL hold the terminal value.
REQ-021 DONE SHALL last one cycle and then go to IDLE, unless start=1, which goes directly to RUN per REQ-015.
REQ-022 In RUN with pause=1, the state SHALL go to PAUSE and cnt SHALL hold.
REQ-023 In PAUSE, cnt SHALL hold while pause=1; with pause=0 the state SHALL return to RUN, and counting resumes on the following edge.
REQ-024 stop=1 SHALL force IDLE from any state with cnt held; stop SHALL override start, pause and tc in the same cycle.
REQ-025 start in RUN or PAUSE SHALL be ignored; changes to limit or dir after capture SHALL have no effect until the next start.
REQ-026 cnt arithmetic SHALL be 4-bit and SHALL never wrap, since the terminal values bound the range to 0..limit_q.
REQ-027 With limit=0, tc SHALL assert in the first RUN cycle, for either dir.
REQ-028 With limit=15 and dir=0, cnt SHALL reach 15 without overflow.

Reset
REQ-029 With rst=0 at an edge: state=IDLE, cnt=0, dir_q=0, limit_q=0, busy=0, done=0; tc SHALL be 0 while in reset.
REQ-030 rst=0 during RUN or PAUSE SHALL abort immediately with no done pulse.

Verification
REQ-031 Scenario: limit=5, dir=0, autoreload=0, 1-cycle start -> cnt 0,1,2,3,4,5; tc=1 on the cnt=5 cycle; done=1 on the next cycle; then IDLE with cnt=5 and busy=0.
REQ-032 Scenario: limit=3, dir=1, autoreload=1, run 10 cycles -> cnt 3,2,1,0,3,2,1,0,3,2; tc on each 0; done never asserts.
REQ-033 Scenario: limit=9, dir=0, pause for 3 cycles while cnt=4 -> cnt stays 4 for those cycles, busy stays 1, counting resumes at 5, done follows cnt=9.
REQ-034 Scenario: limit=7, stop together with pause at cnt=2 -> IDLE, cnt=2, done=0; later start -> cnt=0.
REQ-035 Scenario: limit=0 with dir=0 and dir=1, plus limit=15 with dir=0 -> tc in the first RUN cycle for limit=0; cnt reaches 15 and then done for limit=15.
REQ-036 Scenario: rst=0 at cnt=6 mid-RUN -> next cycle cnt=0, IDLE, busy=0, no done; start held during rst is ignored.
